// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg
//   Shared definitions for the memory access unit.
//   Contents:
//     - LdStCtrl encodings
//     - FSM state encodings
//     - resp_err codes
//     - default timeout
//     - request latch struct
//     - misalignment / store-class helpers
package mem_access_unit_pkg;

   localparam logic [2:0] LDST_LB  = 3'd0;
   localparam logic [2:0] LDST_LH  = 3'd1;
   localparam logic [2:0] LDST_LW  = 3'd2;
   localparam logic [2:0] LDST_LBU = 3'd3;
   localparam logic [2:0] LDST_LHU = 3'd4;
   localparam logic [2:0] LDST_SB  = 3'd5;
   localparam logic [2:0] LDST_SH  = 3'd6;
   localparam logic [2:0] LDST_SW  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_WAIT_R = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   localparam logic [1:0] ERR_OK       = 2'b00;
   localparam logic [1:0] ERR_MISALIGN = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

   localparam int TIMEOUT_DEFAULT = 255;

   // Request fields captured at accept; the address is kept separately
   // because its width is a parameter of the top.
   typedef struct packed {
      logic [2:0]  ctrl;
      logic [4:0]  rd;
      logic [3:0]  we;
      logic [31:0] sdata;
   } req_t;

   function automatic logic is_store(input logic [2:0] ctrl);
      return (ctrl == LDST_SB) || (ctrl == LDST_SH) || (ctrl == LDST_SW);
   endfunction

   function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] lo);
      case (ctrl)
         LDST_LH, LDST_LHU, LDST_SH: return lo[0];
         LDST_LW, LDST_SW:           return |lo;
         default:                    return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align
//   Combinational big-endian lane select and sign/zero extension of a
//   returned memory word.
//   Ports:
//     ld_st_ctrl  in   LdStCtrl of the latched request
//     addr_lo     in   latched addr[1:0]
//     rdata       in   raw memory word
//     data        out  extended load value (0 for stores)
module load_align
   import mem_access_unit_pkg::*;
(
   input  logic [2:0]  ld_st_ctrl,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = 8'h00;
      // byte offset 0 is the most significant lane
      case (addr_lo)
         2'd0: byte_v = rdata[31:24];
         2'd1: byte_v = rdata[23:16];
         2'd2: byte_v = rdata[15:8];
         2'd3: byte_v = rdata[7:0];
         default: byte_v = 8'h00;
      endcase
   end

   assign half_v = addr_lo[1] ? rdata[15:0] : rdata[31:16];

   always_comb begin
      data = 32'h0;
      case (ld_st_ctrl)
         LDST_LB:  data = {{24{byte_v[7]}}, byte_v};
         LDST_LBU: data = {24'h0, byte_v};
         LDST_LH:  data = {{16{half_v[15]}}, half_v};
         LDST_LHU: data = {16'h0, half_v};
         LDST_LW:  data = rdata;
         default:  data = 32'h0;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-side consumer of load/store control. Runs one data-memory
//   transaction per accepted request and returns a writeback response.
//   Build option: MEM_TIMEOUT_EN adds a wait counter that aborts a
//   transaction after TIMEOUT_CYCLES cycles in REQ+WAIT_R (resp_err=10).
//   Ports:
//     clk, rst_n                  clock, async active-low reset
//     req_valid/req_ready         EX request handshake
//     ld_st_ctrl, addr, wdata,
//     rd_idx                      request payload
//     mem_req/mem_we/mem_addr/
//     mem_wdata                   memory request (held until mem_gnt)
//     mem_gnt, mem_rvalid,
//     mem_rdata                   memory grant / read return
//     resp_valid/resp_wen/resp_rd/
//     resp_data/resp_err          one-cycle writeback response
//     stall                       pipeline hold
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        ld_st_ctrl,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   input  logic [4:0]        rd_idx,
   output logic              mem_req,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic              resp_valid,
   output logic              resp_wen,
   output logic [4:0]        resp_rd,
   output logic [31:0]       resp_data,
   output logic [1:0]        resp_err,
   output logic              stall
);

   state_t            st_q, st_nxt;
   req_t              req_q;
   logic [ADDR_W-1:0] addr_q;
   logic [1:0]        err_q;
   logic [31:0]       ldata_q;

   logic [3:0]        st_we;
   logic [31:0]       st_data;
   logic              mis_in;
   logic [31:0]       align_data;
   logic              tmo;

   // store lane enables and replicated data, computed from the live request
   always_comb begin
      st_we   = 4'b0000;
      st_data = 32'h0;
      case (ld_st_ctrl)
         LDST_SB: begin
            st_we   = 4'b1000 >> addr[1:0];
            st_data = {4{wdata[7:0]}};
         end
         LDST_SH: begin
            st_we   = addr[1] ? 4'b0011 : 4'b1100;
            st_data = {2{wdata[15:0]}};
         end
         LDST_SW: begin
            st_we   = 4'b1111;
            st_data = wdata;
         end
         default: begin
            st_we   = 4'b0000;
            st_data = 32'h0;
         end
      endcase
   end

   assign mis_in = is_misaligned(ld_st_ctrl, addr[1:0]);

   load_align u_align (
      .ld_st_ctrl (req_q.ctrl),
      .addr_lo    (addr_q[1:0]),
      .rdata      (mem_rdata),
      .data       (align_data)
   );

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt;

   // cleared in IDLE/RESP, so it is zero on every entry to REQ
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if (st_q == ST_REQ || st_q == ST_WAIT_R)
         wait_cnt <= wait_cnt + CNT_W'(1);
      else
         wait_cnt <= '0;
   end

   // asserted on the TIMEOUT_CYCLES-th wait cycle; a handshake in the same
   // cycle takes priority in the next-state logic
   assign tmo = (st_q == ST_REQ || st_q == ST_WAIT_R) &&
                (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT_CYCLES != 0);
   assign tmo            = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st_q <= ST_IDLE;
      else        st_q <= st_nxt;
   end

   // next state
   always_comb begin
      st_nxt = st_q;
      case (st_q)
         ST_IDLE:
            if (req_valid) st_nxt = mis_in ? ST_RESP : ST_REQ;
         ST_REQ:
            if (mem_gnt)  st_nxt = is_store(req_q.ctrl) ? ST_RESP : ST_WAIT_R;
            else if (tmo) st_nxt = ST_RESP;
         ST_WAIT_R:
            if (mem_rvalid || tmo) st_nxt = ST_RESP;
         ST_RESP:
            st_nxt = ST_IDLE;
         default:
            st_nxt = ST_IDLE;
      endcase
   end

   // request latch, error code and load capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q   <= '0;
         addr_q  <= '0;
         err_q   <= ERR_OK;
         ldata_q <= '0;
      end else begin
         case (st_q)
            ST_IDLE:
               if (req_valid) begin
                  req_q.ctrl  <= ld_st_ctrl;
                  req_q.rd    <= rd_idx;
                  req_q.we    <= st_we;
                  req_q.sdata <= st_data;
                  addr_q      <= addr;
                  err_q       <= mis_in ? ERR_MISALIGN : ERR_OK;
               end
            ST_REQ:
               if (!mem_gnt && tmo) err_q <= ERR_TIMEOUT;
            ST_WAIT_R:
               if (mem_rvalid)  ldata_q <= align_data;
               else if (tmo)    err_q   <= ERR_TIMEOUT;
            default: ;
         endcase
      end
   end

   // outputs: decoded from state and latched registers only
   always_comb begin
      req_ready  = (st_q == ST_IDLE);
      stall      = (st_q != ST_IDLE) || req_valid;

      mem_req    = (st_q == ST_REQ);
      mem_we     = mem_req ? req_q.we    : 4'b0000;
      mem_addr   = mem_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
      mem_wdata  = mem_req ? req_q.sdata : 32'h0;

      resp_valid = (st_q == ST_RESP);
      resp_wen   = resp_valid && !is_store(req_q.ctrl) && (err_q == ERR_OK);
      resp_rd    = resp_valid ? req_q.rd : 5'd0;
      resp_data  = resp_wen   ? ldata_q  : 32'h0;
      resp_err   = resp_valid ? err_q    : ERR_OK;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Lockstep bench: each transaction sets per-cycle expected outputs from a
//   transaction-level model; one negedge process compares them.
//   Define MEM_TIMEOUT_EN to exercise the abort path with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
   localparam int  TO     = 4;
   localparam bit  HAS_TO = 1'b1;
`else
   localparam int  TO     = 255;
   localparam bit  HAS_TO = 1'b0;
`endif

   logic        clk, rst_n;
   logic        req_valid, req_ready;
   logic [2:0]  ld_st_ctrl;
   logic [31:0] addr, wdata;
   logic [4:0]  rd_idx;
   logic        mem_req;
   logic [3:0]  mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt, mem_rvalid;
   logic [31:0] mem_rdata;
   logic        resp_valid, resp_wen;
   logic [4:0]  resp_rd;
   logic [31:0] resp_data;
   logic [1:0]  resp_err;
   logic        stall;

   mem_access_unit #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .ld_st_ctrl(ld_st_ctrl), .addr(addr), .wdata(wdata), .rd_idx(rd_idx),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_rd(resp_rd),
      .resp_data(resp_data), .resp_err(resp_err), .stall(stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
      end
   endfunction

   // ---------------- behavioural model ----------------
   function automatic bit m_store(input logic [2:0] c);
      return c >= 3'd5;
   endfunction

   function automatic bit m_mis(input logic [2:0] c, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      if ((c == 3'd1 || c == 3'd4 || c == 3'd6) && (off % 2) != 0) return 1'b1;
      if ((c == 3'd2 || c == 3'd7) && off != 0) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [3:0] m_we(input logic [2:0] c, input logic [31:0] a);
      int off;
      off = int'(a % 4);
      case (c)
         3'd5:    return 4'(1 << (3 - off));
         3'd6:    return (off < 2) ? 4'hC : 4'h3;
         3'd7:    return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_wd(input logic [2:0] c, input logic [31:0] w);
      case (c)
         3'd5:    return (w & 32'hFF) * 32'h01010101;
         3'd6:    return (w & 32'hFFFF) * 32'h00010001;
         3'd7:    return w;
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] c, input logic [31:0] a, input logic [31:0] w);
      int off, v;
      off = int'(a % 4);
      case (c)
         3'd0, 3'd3: begin
            v = int'((w >> ((3 - off) * 8)) & 32'hFF);
            if (c == 3'd0 && v > 127) v = v - 256;
            return 32'(v);
         end
         3'd1, 3'd4: begin
            v = int'((w >> ((2 - off) * 8)) & 32'hFFFF);
            if (c == 3'd1 && v > 32767) v = v - 65536;
            return 32'(v);
         end
         3'd2:    return w;
         default: return 32'h0;
      endcase
   endfunction

   // ---------------- per-cycle expectations ----------------
   bit          chk_en = 1'b0;
   logic        e_ready, e_stall, e_mreq, e_resp, e_wen, e_chkwd;
   logic [3:0]  e_we;
   logic [31:0] e_maddr, e_mwdata, e_rdata;
   logic [4:0]  e_rd;
   logic [1:0]  e_err;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",  32'(req_ready),  32'(e_ready));
         chk("stall",      32'(stall),      32'(e_stall));
         chk("mem_req",    32'(mem_req),    32'(e_mreq));
         chk("resp_valid", 32'(resp_valid), 32'(e_resp));
         if (e_mreq) begin
            chk("mem_we",   32'(mem_we), 32'(e_we));
            chk("mem_addr", mem_addr,    e_maddr);
            if (e_chkwd) chk("mem_wdata", mem_wdata, e_mwdata);
         end
         if (e_resp) begin
            chk("resp_err",  32'(resp_err), 32'(e_err));
            chk("resp_wen",  32'(resp_wen), 32'(e_wen));
            chk("resp_data", resp_data,     e_rdata);
            if (e_wen) chk("resp_rd", 32'(resp_rd), 32'(e_rd));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_idle();
      req_valid  = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      e_ready = 1'b1; e_stall = 1'b0; e_mreq = 1'b0; e_resp = 1'b0;
      e_wen = 1'b0; e_chkwd = 1'b0;
   endtask

   task automatic idle_cycles(input int n);
      exp_idle();
      repeat (n) step();
   endtask

   // one full transaction; gd = cycles before gnt, rvd = cycles from gnt to rvalid (>=1)
   task automatic run_txn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int gd, input int rvd, input logic [31:0] rdat);
      int  w, since;
      bit  granted, done, complete, progress;
      logic [1:0] err;
      // cycle 0: present request in IDLE
      req_valid = 1'b1; ld_st_ctrl = c; addr = a; wdata = wd; rd_idx = rd;
      mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      e_ready = 1'b1; e_stall = 1'b1; e_mreq = 1'b0; e_resp = 1'b0;
      step();
      // payload must have been latched: scramble it
      req_valid = 1'b0; ld_st_ctrl = 3'($urandom); addr = $urandom; wdata = $urandom;
      rd_idx = 5'($urandom);
      e_ready = 1'b0; e_stall = 1'b1;
      err = 2'b00;
      if (m_mis(c, a)) begin
         mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
         err = 2'b01;
      end else begin
         w = 0; since = 0; granted = 1'b0; done = 1'b0;
         e_we = m_we(c, a); e_maddr = a & ~32'h3; e_mwdata = m_wd(c, wd); e_chkwd = m_store(c);
         while (!done) begin
            w++;
            complete = 1'b0; progress = 1'b0;
            e_mreq = !granted;
            if (!granted) begin
               mem_gnt    = (w > gd);
               mem_rvalid = mem_gnt;       // same-cycle rvalid must be ignored
               mem_rdata  = $urandom;
               progress   = mem_gnt;
               complete   = mem_gnt && m_store(c);
               if (mem_gnt) granted = 1'b1;
            end else begin
               since++;
               mem_gnt    = 1'b0;
               mem_rvalid = (since >= rvd);
               mem_rdata  = mem_rvalid ? rdat : $urandom;
               progress   = mem_rvalid;
               complete   = mem_rvalid;
            end
            step();
            if (complete) done = 1'b1;
            else if (HAS_TO && w >= TO && !progress) begin
               done = 1'b1;
               err  = 2'b10;
            end
         end
         // spurious handshakes during RESP
         mem_gnt = 1'($urandom_range(0, 1)); mem_rvalid = 1'($urandom_range(0, 1));
      end
      e_mreq  = 1'b0;
      e_resp  = 1'b1;
      e_err   = err;
      e_wen   = !m_store(c) && err == 2'b00;
      e_rdata = e_wen ? m_load(c, a, rdat) : 32'h0;
      e_rd    = rd;
      step();
      exp_idle();
   endtask

   initial begin
      int gd, rvd;
      logic [2:0] c;
      rst_n = 1'b0; req_valid = 1'b0; ld_st_ctrl = 3'd0; addr = 32'h0; wdata = 32'h0;
      rd_idx = 5'd0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
      exp_idle();
      repeat (2) step();

      // reset state
      chk("rst_req_ready",  32'(req_ready),  32'd1);
      chk("rst_stall",      32'(stall),      32'd0);
      chk("rst_mem_req",    32'(mem_req),    32'd0);
      chk("rst_mem_we",     32'(mem_we),     32'd0);
      chk("rst_mem_addr",   mem_addr,        32'd0);
      chk("rst_mem_wdata",  mem_wdata,       32'd0);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_wen",   32'(resp_wen),   32'd0);
      chk("rst_resp_rd",    32'(resp_rd),    32'd0);
      chk("rst_resp_data",  resp_data,       32'd0);
      chk("rst_resp_err",   32'(resp_err),   32'd0);

      // hand-computed pins for the model
      chk("pin_sw_we",  32'(m_we(3'd7, 32'h100)),       32'hF);
      chk("pin_sb_we",  32'(m_we(3'd5, 32'h103)),       32'h1);
      chk("pin_sb_wd",  m_wd(3'd5, 32'h000000A5),        32'hA5A5A5A5);
      chk("pin_sh_we",  32'(m_we(3'd6, 32'h102)),       32'h3);
      chk("pin_lb",     m_load(3'd0, 32'h101, 32'h1280FF34), 32'hFFFFFF80);
      chk("pin_lbu",    m_load(3'd3, 32'h101, 32'h1280FF34), 32'h00000080);
      chk("pin_lhu",    m_load(3'd4, 32'h102, 32'hAAAA8001), 32'h00008001);
      chk("pin_lh",     m_load(3'd1, 32'h100, 32'hAAAA8001), 32'hFFFFAAAA);
      chk("pin_mis_lw", 32'(m_mis(3'd2, 32'h102)),      32'd1);

      rst_n = 1'b1;
      exp_idle();
      chk_en = 1'b1;
      step();

      // directed
      run_txn(3'd7, 32'h100, 32'hDEADBEEF, 5'd1, 0, 1, 32'h0);
      run_txn(3'd5, 32'h103, 32'h000000A5, 5'd2, 0, 1, 32'h0);
      run_txn(3'd0, 32'h101, 32'h0, 5'd7, 0, 1, 32'h1280FF34);
      run_txn(3'd3, 32'h101, 32'h0, 5'd7, 0, 1, 32'h1280FF34);
`ifdef MEM_TIMEOUT_EN
      run_txn(3'd4, 32'h102, 32'h0, 5'd9, 1, 2, 32'hAAAA8001);
`else
      run_txn(3'd4, 32'h102, 32'h0, 5'd9, 3, 2, 32'hAAAA8001);
`endif
      run_txn(3'd2, 32'h102, 32'h0, 5'd4, 0, 1, 32'h0);
      run_txn(3'd6, 32'h102, 32'h0000BEEF, 5'd3, 1, 1, 32'h0);
      run_txn(3'd1, 32'h100, 32'h0, 5'd31, 0, 1, 32'hAAAA8001);
      idle_cycles(2);

`ifdef MEM_TIMEOUT_EN
      // no grant at all: abort after TO wait cycles
      run_txn(3'd2, 32'h200, 32'h0, 5'd5, 1000, 1, 32'h0);
      // grant on the final wait cycle: completion wins
      run_txn(3'd7, 32'h204, 32'h12345678, 5'd6, TO - 1, 1, 32'h0);
      // load whose rvalid lands on the final wait cycle
      run_txn(3'd2, 32'h208, 32'h0, 5'd8, 1, 2, 32'hCAFEF00D);
`endif

      // reset while waiting for read data
      req_valid = 1'b1; ld_st_ctrl = 3'd2; addr = 32'h300; rd_idx = 5'd10;
      e_ready = 1'b1; e_stall = 1'b1; e_mreq = 1'b0; e_resp = 1'b0;
      step();
      req_valid = 1'b0; mem_gnt = 1'b1;
      e_ready = 1'b0; e_mreq = 1'b1; e_we = 4'h0; e_maddr = 32'h300; e_chkwd = 1'b0;
      step();
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      chk_en = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready",  32'(req_ready),  32'd1);
      chk("midrst_stall",      32'(stall),      32'd0);
      chk("midrst_mem_req",    32'(mem_req),    32'd0);
      chk("midrst_mem_we",     32'(mem_we),     32'd0);
      chk("midrst_mem_addr",   mem_addr,        32'd0);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_data",  resp_data,       32'd0);
      chk("midrst_resp_err",   32'(resp_err),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         mem_rvalid = 1'b1; mem_rdata = $urandom;
         #1;
         chk("postrst_resp_valid", 32'(resp_valid), 32'd0);
         chk("postrst_req_ready",  32'(req_ready),  32'd1);
      end
      exp_idle();
      step();
      chk_en = 1'b1;

      // randomized
      for (int n = 0; n < 200; n++) begin
         c = 3'($urandom);
`ifdef MEM_TIMEOUT_EN
         if (c >= 3'd5) begin
            gd = $urandom_range(0, 3); rvd = 1;
         end else begin
            gd = $urandom_range(0, 1); rvd = $urandom_range(1, 3 - gd);
         end
`else
         gd = $urandom_range(0, 4); rvd = $urandom_range(1, 4);
`endif
         run_txn(c, $urandom, $urandom, 5'($urandom), gd, rvd, $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 3));
      end

      idle_cycles(2);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
